glyph_sequencer: RTL and testbench
==================================

# glyph_sequencer

Row-data source for the 5x7 LED matrix. Sits between the 3-bit column scanner, which produces the one-hot column strobes C1..C5, and the matrix row lines L1..L7. It cycles through a fixed message of glyphs from a 5-column font. Each glyph is held for a programmable number of frames, followed by optional blank frames. Row and column outputs are re-registered together so they stay aligned on the matrix pins.

## Interface
Parameters:
- FRAMES_PER_CHAR, 50: frames each glyph is shown; legal range ≥1.
- BLANK_FRAMES, 5: all-dark frames inserted after each glyph; 0 means no blanking.
- MSG_LEN, 3: number of glyphs in the message; legal range 1..3.

Ports:
- CLK  in  1  system clock; sole clock domain.
- RST_N  in  1  reset; synchronous, active-low.
- COL  in  5  one-hot column strobe from the scanner; COL[0]=C1 … COL[4]=C5.
- EN  in  1  display enable; when 0, counters freeze and rows are dark.
- COL_Q  out  5  COL delayed one cycle; this drives the matrix columns.
- ROW  out  7  row pattern aligned with COL_Q; ROW[0]=L1 … ROW[6]=L7.
- CHAR_IDX  out  2  index of the glyph currently shown.
- BLANKING  out  1  1 while in the BLANK state.

## Operation
- Message order: index 0 = "A", 1 = "G", 2 = "0". Indices ≥ MSG_LEN are never reached.
- Font: per-column row bytes, listed C1..C5, bit0 = L1.
  - "A": 00,6E,6E,6E,00
  - "G": 00,3E,3E,36,06
  - "0": 00,3E,3E,3E,00
- Frame boundary: a cycle where COL==5'b00001 and, on the previous cycle, COL was not 5'b00001.
  - The previous-C1 flag resets to 0, so the first C1 after reset counts as a boundary.
- States:
  - SHOW: glyph pattern is displayed.
  - BLANK: ROW is forced to 0.
- Frame counter: FCNT, width $clog2(max(FRAMES_PER_CHAR, BLANK_FRAMES, 2)).
- Transitions, evaluated only on boundary cycles with EN=1:
  - SHOW, FCNT==FRAMES_PER_CHAR-1:
    - If BLANK_FRAMES>0: go to BLANK, FCNT←0.
    - If BLANK_FRAMES==0: stay in SHOW, FCNT←0, CHAR_IDX advances.
  - SHOW otherwise: FCNT+1.
  - BLANK, FCNT==BLANK_FRAMES-1: go to SHOW, FCNT←0, CHAR_IDX advances.
  - BLANK otherwise: FCNT+1.
- CHAR_IDX advance: CHAR_IDX==MSG_LEN-1 wraps to 0; otherwise +1. With MSG_LEN=1 it stays at 0.
- Row selection uses the next-state values, so a new glyph or blanking takes effect from the first column of the new frame. No frame shows a mix of two glyphs.
- Invalid COL (zero or multi-hot): ROW←0 on the next cycle, COL_Q←COL. No boundary is detected and no state change occurs.
- EN=0:
  - ROW←0; COL_Q continues to track COL.
  - State, FCNT and CHAR_IDX hold.
  - Boundaries seen while EN=0 are ignored.
  - The previous-C1 flag keeps updating, so EN rising mid-frame cannot create a false boundary.

## Timing
- Reset values: ROW=0, COL_Q=0, CHAR_IDX=0, BLANKING=0, state=SHOW, FCNT=0, previous-C1 flag=0.
- Latency: COL→COL_Q and COL→ROW are both exactly 1 cycle, so the pair is always mutually aligned.
- Reset mid-frame: everything returns to reset values on the next edge. The first post-reset C1 is a boundary, counted as frame 1 of glyph 0.
- BLANKING and CHAR_IDX are registered and change on the same edge as the first ROW of the new frame.
- Column dwell: any length ≥1 cycle per column is supported. Only the C1 rising edge matters.

## Structure
- Package glyph_pkg holds:
  - the state enum (SHOW, BLANK);
  - the font constant: 3 glyphs × 5 columns × 7 bits;
  - the glyph-code localparams A/G/ZERO and the message-order array.
- Sub-module glyph_rom (combinational): glyph index plus one-hot column in, 7-bit row out, 0 for invalid columns.
- Top block: boundary detector, FSM/counters, output registers.

## Test plan
- Reset, then scan C1..C5 with 1-cycle columns: ROW = 00,6E,6E,6E,00, each 1 cycle after its COL; COL_Q equals COL delayed by 1.
- FRAMES_PER_CHAR=2, BLANK_FRAMES=1, 10 frames:
  - glyph sequence A,A,blank,G,G,blank,0,0,blank,A;
  - BLANKING is high only in frames 3, 6 and 9.
- BLANK_FRAMES=0, MSG_LEN=2: sequence alternates A,G with no dark frame; CHAR_IDX alternates 0,1.
- Columns held 4 cycles each plus an illegal COL=5'b00011 mid-frame:
  - ROW=0 only for the illegal cycle;
  - FCNT is unchanged;
  - no extra glyph advance.
- EN deasserted for 3 frames starting mid-frame, then reasserted mid-frame:
  - ROW=0 throughout the EN=0 period;
  - counting resumes exactly where it stopped, with no spurious boundary.
- RST_N asserted during the "G" BLANK state: all outputs are 0 on the next cycle; the next C1 shows "A".

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared types and constants for the 5x7 LED matrix glyph sequencer.
// Holds the state encoding, the 5-column font, the glyph codes and the
// message order, plus a helper that maps a message index to a glyph code.
package glyph_pkg;

    localparam int unsigned ROW_W      = 7;
    localparam int unsigned COL_W      = 5;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NUM_GLYPHS = 3;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_e;

    // Glyph codes index the first dimension of FONT.
    localparam logic [IDX_W-1:0] GLYPH_A    = 2'd0;
    localparam logic [IDX_W-1:0] GLYPH_G    = 2'd1;
    localparam logic [IDX_W-1:0] GLYPH_ZERO = 2'd2;

    // Message order: position 0 is shown first.
    localparam logic [0:2][IDX_W-1:0] MSG_ORDER = '{GLYPH_A, GLYPH_G, GLYPH_ZERO};

    // Per-column row bytes, columns C1..C5, bit0 = L1.
    localparam logic [0:2][0:4][ROW_W-1:0] FONT = '{
        '{7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00},   // "A"
        '{7'h00, 7'h3E, 7'h3E, 7'h36, 7'h06},   // "G"
        '{7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00}    // "0"
    };

    // Message position to glyph code; unused positions map to "A".
    function automatic logic [IDX_W-1:0] msg_glyph(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] g;
        case (idx)
            2'd1:    g = MSG_ORDER[1];
            2'd2:    g = MSG_ORDER[2];
            default: g = MSG_ORDER[0];
        endcase
        return g;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Combinational font lookup.
// Ports:
//   glyph  - glyph code (0..NUM_GLYPHS-1)
//   col    - one-hot column strobe, col[0] = C1
//   row_c  - 7-bit row pattern; 0 for zero/multi-hot columns or unknown glyphs
module glyph_rom
    import glyph_pkg::*;
(
    input  logic [IDX_W-1:0] glyph,
    input  logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row_c
);

    logic [2:0] col_idx;
    logic       col_ok;

    // One-hot column to column index; anything else is not a valid column.
    always_comb begin
        col_idx = 3'd0;
        col_ok  = 1'b0;
        case (col)
            5'b00001: begin col_idx = 3'd0; col_ok = 1'b1; end
            5'b00010: begin col_idx = 3'd1; col_ok = 1'b1; end
            5'b00100: begin col_idx = 3'd2; col_ok = 1'b1; end
            5'b01000: begin col_idx = 3'd3; col_ok = 1'b1; end
            5'b10000: begin col_idx = 3'd4; col_ok = 1'b1; end
            default:  begin col_idx = 3'd0; col_ok = 1'b0; end
        endcase
    end

    // Font read, dark when the column or glyph is out of range.
    always_comb begin
        row_c = '0;
        if (col_ok && (glyph < IDX_W'(NUM_GLYPHS))) begin
            row_c = FONT[glyph][col_idx];
        end
    end

endmodule

// File: rtl/glyph_sequencer.sv
// Row-data source for a 5x7 LED matrix. Walks a fixed message of glyphs,
// holding each for FRAMES_PER_CHAR frames followed by BLANK_FRAMES dark
// frames. Row and column are re-registered together so they stay aligned.
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   col       - one-hot column strobe from the scanner, col[0] = C1
//   en        - display enable; 0 freezes counters and darkens rows
//   col_q     - col delayed one cycle, drives the matrix columns
//   row       - row pattern aligned with col_q, row[0] = L1
//   char_idx  - message position currently shown
//   blanking  - 1 while in the BLANK state
module glyph_sequencer
    import glyph_pkg::*;
#(
    parameter int unsigned FRAMES_PER_CHAR = 50,
    parameter int unsigned BLANK_FRAMES    = 5,
    parameter int unsigned MSG_LEN         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COL_W-1:0] col,
    input  logic             en,
    output logic [COL_W-1:0] col_q,
    output logic [ROW_W-1:0] row,
    output logic [IDX_W-1:0] char_idx,
    output logic             blanking
);

    localparam int unsigned FMAX   = (FRAMES_PER_CHAR > BLANK_FRAMES) ? FRAMES_PER_CHAR : BLANK_FRAMES;
    localparam int unsigned FMAX2  = (FMAX > 2) ? FMAX : 2;
    localparam int unsigned FCNT_W = $clog2(FMAX2);

    localparam logic [FCNT_W-1:0] SHOW_LAST  = FCNT_W'(FRAMES_PER_CHAR - 1);
    localparam logic [FCNT_W-1:0] BLANK_LAST = FCNT_W'((BLANK_FRAMES > 0) ? (BLANK_FRAMES - 1) : 0);
    localparam logic [IDX_W-1:0]  CHAR_LAST  = IDX_W'(MSG_LEN - 1);

    localparam logic [0:0] S_SHOW  = 1'(SHOW);
    localparam logic [0:0] S_BLANK = 1'(BLANK);

    logic [0:0]        state_q, state_n;
    logic [FCNT_W-1:0] fcnt_q, fcnt_n;
    logic [IDX_W-1:0]  char_n;
    logic [IDX_W-1:0]  char_inc_c;
    logic              prev_c1_q;
    logic              primed_q, primed_n;
    logic              is_c1_c;
    logic              step_c;
    logic [IDX_W-1:0]  glyph_c;
    logic [ROW_W-1:0]  rom_row_c;
    logic [ROW_W-1:0]  row_d_c;

    // Frame boundary: rising edge of the C1 strobe, honoured only when enabled.
    assign is_c1_c = (col == 5'b00001);
    assign step_c  = is_c1_c && !prev_c1_q && en;

    assign char_inc_c = (char_idx == CHAR_LAST) ? '0 : (char_idx + IDX_W'(1));

    // Next-state logic. The first boundary after reset only opens frame 1
    // of glyph 0, so every glyph gets its full frame count.
    always_comb begin
        state_n  = state_q;
        fcnt_n   = fcnt_q;
        char_n   = char_idx;
        primed_n = primed_q;
        if (step_c) begin
            if (!primed_q) begin
                primed_n = 1'b1;
            end else begin
                case (state_q)
                    S_SHOW: begin
                        if (fcnt_q == SHOW_LAST) begin
                            fcnt_n = '0;
                            if (BLANK_FRAMES > 0) begin
                                state_n = S_BLANK;
                            end else begin
                                char_n = char_inc_c;
                            end
                        end else begin
                            fcnt_n = fcnt_q + FCNT_W'(1);
                        end
                    end
                    S_BLANK: begin
                        if (fcnt_q == BLANK_LAST) begin
                            state_n = S_SHOW;
                            fcnt_n  = '0;
                            char_n  = char_inc_c;
                        end else begin
                            fcnt_n = fcnt_q + FCNT_W'(1);
                        end
                    end
                    default: begin
                        state_n = S_SHOW;
                        fcnt_n  = '0;
                    end
                endcase
            end
        end
    end

    // Rows follow the next-state values so a new glyph starts on the
    // first column of its frame.
    assign glyph_c = msg_glyph(char_n);

    glyph_rom u_rom (
        .glyph (glyph_c),
        .col   (col),
        .row_c (rom_row_c)
    );

    assign row_d_c = (en && (state_n == S_SHOW)) ? rom_row_c : '0;

    // State, counters and aligned output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_SHOW;
            fcnt_q    <= '0;
            char_idx  <= '0;
            primed_q  <= 1'b0;
            prev_c1_q <= 1'b0;
            col_q     <= '0;
            row       <= '0;
            blanking  <= 1'b0;
        end else begin
            state_q   <= state_n;
            fcnt_q    <= fcnt_n;
            char_idx  <= char_n;
            primed_q  <= primed_n;
            prev_c1_q <= is_c1_c;
            col_q     <= col;
            row       <= row_d_c;
            blanking  <= (state_n == S_BLANK);
        end
    end

endmodule

// File: tb/tb_glyph_sequencer.sv
// Directed bench for glyph_sequencer. Three instances share one stimulus:
//   u_a: defaults (50/5/3), u_b: 2 show / 1 blank / 3 glyphs,
//   u_c: 1 show / 0 blank / 2 glyphs.
// Expected glyph per frame is hand-written per instance; row bytes come
// from a local copy of the font.
module tb_glyph_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] col;

    logic [4:0] a_col_q, b_col_q, c_col_q;
    logic [6:0] a_row, b_row, c_row;
    logic [1:0] a_char, b_char, c_char;
    logic       a_blank, b_blank, c_blank;

    int checks   = 0;
    int failures = 0;
    int frame    = 1;

    always #5 clk = ~clk;

    glyph_sequencer u_a (
        .clk(clk), .rst_n(rst_n), .col(col), .en(en),
        .col_q(a_col_q), .row(a_row), .char_idx(a_char), .blanking(a_blank)
    );

    glyph_sequencer #(.FRAMES_PER_CHAR(2), .BLANK_FRAMES(1), .MSG_LEN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .col(col), .en(en),
        .col_q(b_col_q), .row(b_row), .char_idx(b_char), .blanking(b_blank)
    );

    glyph_sequencer #(.FRAMES_PER_CHAR(1), .BLANK_FRAMES(0), .MSG_LEN(2)) u_c (
        .clk(clk), .rst_n(rst_n), .col(col), .en(en),
        .col_q(c_col_q), .row(c_row), .char_idx(c_char), .blanking(c_blank)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL f%0d %s got=%0h exp=%0h", frame, tag, got, exp);
        end
    endtask

    // Glyph 0="A", 1="G", 2="0", 3=dark frame.
    function automatic logic [6:0] exp_row(input int g, input logic [4:0] cv);
        int ci;
        case (cv)
            5'b00001: ci = 0;
            5'b00010: ci = 1;
            5'b00100: ci = 2;
            5'b01000: ci = 3;
            5'b10000: ci = 4;
            default:  return 7'h00;
        endcase
        case (g)
            0: case (ci) 1, 2, 3: return 7'h6E; default: return 7'h00; endcase
            1: case (ci) 1, 2: return 7'h3E; 3: return 7'h36; 4: return 7'h06; default: return 7'h00; endcase
            2: case (ci) 1, 2, 3: return 7'h3E; default: return 7'h00; endcase
            default: return 7'h00;
        endcase
    endfunction

    // One cycle of stimulus, then check rows and column echo of every instance.
    task automatic step(input logic [4:0] cv, input logic ev, input int gb, input int gc);
        @(negedge clk);
        col = cv;
        en  = ev;
        @(posedge clk);
        #1;
        chk("row_a", 32'(a_row), 32'(ev ? exp_row(0, cv) : 7'h00));
        chk("row_b", 32'(b_row), 32'(ev ? exp_row(gb, cv) : 7'h00));
        chk("row_c", 32'(c_row), 32'(ev ? exp_row(gc, cv) : 7'h00));
        chk("colq_b", 32'(b_col_q), 32'(cv));
        chk("colq_c", 32'(c_col_q), 32'(cv));
    endtask

    task automatic chk_state(input int cb, input int blk_b, input int cc);
        chk("char_a", 32'(a_char), 32'd0);
        chk("blank_a", 32'(a_blank), 32'd0);
        chk("char_b", 32'(b_char), 32'(cb));
        chk("blank_b", 32'(b_blank), 32'(blk_b));
        chk("char_c", 32'(c_char), 32'(cc));
        chk("blank_c", 32'(c_blank), 32'd0);
    endtask

    // Full enabled frame; gb=3 means u_b is dark, cb is u_b's message index.
    task automatic frame_run(input int gb, input int cb, input int gc, input int dwell);
        logic [4:0] cv;
        for (int i = 0; i < 5; i++) begin
            cv = 5'b00001 << i;
            for (int d = 0; d < dwell; d++) begin
                step(cv, 1'b1, gb, gc);
                if (i == 0 && d == 0) chk_state(cb, (gb == 3) ? 1 : 0, gc);
            end
        end
        frame++;
    endtask

    task automatic hold(input logic [4:0] cv, input int n, input logic ev, input int gb, input int gc);
        for (int d = 0; d < n; d++) step(cv, ev, gb, gc);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        col   = 5'b00001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_a", 32'(a_row), 32'd0);
        chk("rst_colq_a", 32'(a_col_q), 32'd0);
        chk("rst_row_b", 32'(b_row), 32'd0);
        chk("rst_colq_b", 32'(b_col_q), 32'd0);
        chk_state(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        col   = 5'b00000;

        // Frames 1-10: single-cycle columns.
        frame_run(0, 0, 0, 1);
        frame_run(0, 0, 1, 1);
        frame_run(3, 0, 0, 1);
        frame_run(1, 1, 1, 1);
        frame_run(1, 1, 0, 1);
        frame_run(3, 1, 1, 1);
        frame_run(2, 2, 0, 1);
        frame_run(2, 2, 1, 1);
        frame_run(3, 2, 0, 1);
        frame_run(0, 0, 1, 1);

        // Frame 11: 4-cycle columns with one illegal strobe inside C3.
        step(5'b00001, 1'b1, 0, 0);
        chk_state(0, 0, 0);
        hold(5'b00001, 3, 1'b1, 0, 0);
        hold(5'b00010, 4, 1'b1, 0, 0);
        hold(5'b00100, 2, 1'b1, 0, 0);
        step(5'b00011, 1'b1, 0, 0);
        chk("illegal_row_b", 32'(b_row), 32'd0);
        hold(5'b00100, 2, 1'b1, 0, 0);
        hold(5'b01000, 4, 1'b1, 0, 0);
        hold(5'b10000, 4, 1'b1, 0, 0);
        frame++;

        frame_run(3, 0, 1, 1);
        frame_run(1, 1, 0, 1);

        // Frame 14: enable drops after C2.
        step(5'b00001, 1'b1, 1, 1);
        chk_state(1, 0, 1);
        step(5'b00010, 1'b1, 1, 1);
        step(5'b00100, 1'b0, 1, 1);
        step(5'b01000, 1'b0, 1, 1);
        step(5'b10000, 1'b0, 1, 1);
        frame++;

        // Frames 15-17 fully disabled.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 5; i++) step(5'b00001 << i, 1'b0, 1, 1);
            chk_state(1, 0, 1);
            frame++;
        end

        // Frame 18: enable returns at C3, glyph state unchanged.
        step(5'b00001, 1'b0, 1, 1);
        step(5'b00010, 1'b0, 1, 1);
        step(5'b00100, 1'b1, 1, 1);
        chk_state(1, 0, 1);
        step(5'b01000, 1'b1, 1, 1);
        step(5'b10000, 1'b1, 1, 1);
        frame++;

        frame_run(3, 1, 0, 1);
        frame_run(2, 2, 1, 1);
        frame_run(2, 2, 0, 1);
        frame_run(3, 2, 1, 1);
        frame_run(0, 0, 0, 1);
        frame_run(0, 0, 1, 1);
        frame_run(3, 0, 0, 1);
        frame_run(1, 1, 1, 1);
        frame_run(1, 1, 0, 1);

        // Frame 28: blank after "G", reset applied at C3.
        step(5'b00001, 1'b1, 3, 1);
        chk_state(1, 1, 1);
        step(5'b00010, 1'b1, 3, 1);
        @(negedge clk);
        col   = 5'b00100;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_row_b", 32'(b_row), 32'd0);
        chk("mrst_colq_b", 32'(b_col_q), 32'd0);
        chk("mrst_row_a", 32'(a_row), 32'd0);
        chk("mrst_colq_c", 32'(c_col_q), 32'd0);
        chk_state(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b01000, 1'b1, 0, 0);
        step(5'b10000, 1'b1, 0, 0);
        frame++;

        // Frames 29-31: post-reset C1 is frame 1 of "A".
        frame_run(0, 0, 0, 1);
        frame_run(0, 0, 1, 1);
        frame_run(3, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
